// File: rtl/flaf_pkg.sv
// Shared types and helpers for the functional-link adaptive filter blocks.
package flaf_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_QP    = 12;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } sched_state_t;

    // Half an LSB of the output slice, added before truncation so the slice rounds half-up.
    function automatic logic [63:0] round_const(input int qp, input int shift);
        return 64'd1 << (qp + shift - 1);
    endfunction

endpackage

// File: rtl/wupd_mac.sv
// Registered multiply-round-slice stage: inc_r <= round(x * mu) in the Q format.
module wupd_mac
    import flaf_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int QP    = DEFAULT_QP,
    parameter int SHIFT = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] mu,
    output logic signed [WIDTH-1:0] inc_r
);

    localparam logic signed [2*WIDTH-1:0] RND = (2*WIDTH)'(round_const(QP, SHIFT));

    logic signed [2*WIDTH-1:0] full;
    logic signed [WIDTH-1:0]   inc_next;

    // Full-precision product plus rounding constant, then an arithmetic shift keeps the slice.
    always_comb begin
        full     = (2*WIDTH)'(x) * (2*WIDTH)'(mu) + RND;
        inc_next = WIDTH'(full >>> (QP + SHIFT));
    end

    // Capture the increment only when a valid feature is on x.
    always_ff @(posedge clk) begin
        if (reset) begin
            inc_r <= '0;
        end else if (en) begin
            inc_r <= inc_next;
        end
    end

endmodule

// File: rtl/flaf_wupd_sched.sv
// Weight-update scheduler: one pass per start walks all taps through a shared MAC,
// applying w[i] += round(x[i] * mu_error) to the internal weight bank.
module flaf_wupd_sched
    import flaf_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int QP    = DEFAULT_QP,
    parameter int SHIFT = 0,
    parameter int TAPS  = 8,
    parameter int AW    = $clog2(TAPS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] mu_error,
    output logic        [AW-1:0]    x_addr,
    input  logic signed [WIDTH-1:0] x_data,
    input  logic        [AW-1:0]    w_rd_addr,
    output logic signed [WIDTH-1:0] w_rd_data,
    output logic                    busy,
    output logic                    done
);

    localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);

    sched_state_t            state;
    sched_state_t            state_next;
    logic                    accept;
    logic                    issue;
    logic                    drain_last;
    logic signed [WIDTH-1:0] mu_r;
    logic                    p1_valid;
    logic                    p2_valid;
    logic [AW-1:0]           p1_tap;
    logic [AW-1:0]           p2_tap;
    logic signed [WIDTH-1:0] inc_r;
    logic signed [WIDTH-1:0] weights [TAPS];

    // Next-state logic: accept start only in IDLE, issue one tap per cycle, drain two cycles.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                issue = 1'b1;
                if (x_addr == LAST_TAP) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Control registers: latched step, tap address (held outside ISSUE), drain phase and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            mu_r       <= '0;
            x_addr     <= '0;
            drain_last <= 1'b0;
            done       <= 1'b0;
        end else begin
            done       <= (state == DRAIN) && drain_last;
            drain_last <= (state == DRAIN) && !drain_last;
            if (accept) begin
                mu_r   <= mu_error;
                x_addr <= '0;
            end else if (issue && (x_addr != LAST_TAP)) begin
                x_addr <= x_addr + AW'(1);
            end
        end
    end

    // Tap tags follow the data through the feature read and the MAC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            p1_valid <= 1'b0;
            p2_valid <= 1'b0;
            p1_tap   <= '0;
            p2_tap   <= '0;
        end else begin
            p1_valid <= issue;
            p1_tap   <= x_addr;
            p2_valid <= p1_valid;
            p2_tap   <= p1_tap;
        end
    end

    wupd_mac #(
        .WIDTH (WIDTH),
        .QP    (QP),
        .SHIFT (SHIFT)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .en    (p1_valid),
        .x     (x_data),
        .mu    (mu_r),
        .inc_r (inc_r)
    );

    // Weight bank: wrapping accumulate of the registered increment into the tagged tap.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                weights[i] <= '0;
            end
        end else if (p2_valid) begin
            weights[p2_tap] <= weights[p2_tap] + inc_r;
        end
    end

    assign w_rd_data = weights[w_rd_addr];
    assign busy      = (state != IDLE);

endmodule
